// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder and its two-client arbiter.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned REQ_N         = 2;

endpackage

// File: rtl/HalfAdd.sv
// Half adder: sum and carry of two single bits.
module HalfAdd (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_add_bit.sv
// One-bit full adder built from two half adders and an OR of their carries.
module full_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  HalfAdd u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  HalfAdd u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

  assign cout = c1 | c2;

endmodule

// File: rtl/serial_add_arb.sv
// Bit-serial adder shared by two requesters: round-robin capture of an operand
// pair, then one full-adder bit per clock, LSB first, over WIDTH cycles.
module serial_add_arb
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               CLK,
  input  logic               Reset_L,
  input  logic [REQ_N-1:0]   req,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic [REQ_N-1:0]   gnt,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [WIDTH-1:0]   sum,
  output logic               cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rr_q, rr_d;
  logic               sel_q, sel_d;
  logic [REQ_N-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               fa_s;
  logic               fa_c;
  logic               pick;

  full_add_bit u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // With both requesting, serve the one that did not win last time.
  always_comb begin
    if (req[0] && req[1]) pick = ~rr_q;
    else                  pick = req[1];
  end

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    work_d    = work_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;

    case (state_q)
      IDLE: begin
        if (req != '0) begin
          opa_d       = pick ? a1 : a0;
          opb_d       = pick ? b1 : b0;
          work_d      = '0;
          carry_d     = 1'b0;
          cnt_d       = '0;
          rr_d        = pick;
          sel_d       = pick;
          gnt_d[pick] = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        // Shift-then-insert keeps the WIDTH=1 case free of an empty slice.
        work_d  = work_q >> 1;
        work_d[WIDTH-1] = fa_s;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d     = work_d;
          cout_d    = fa_c;
          done_id_d = sel_q;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      work_q    <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      rr_q      <= 1'b1;
      sel_q     <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      work_q    <= work_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_add_arb.sv
// Directed bench for serial_add_arb at WIDTH=8 and WIDTH=1.
module tb_serial_add_arb;

  logic CLK = 1'b0;
  logic Reset_L;

  always #5 CLK = ~CLK;

  logic [1:0] req8;
  logic [7:0] a0_8, b0_8, a1_8, b1_8;
  logic [1:0] gnt8;
  logic       busy8, done8, done_id8, cout8;
  logic [7:0] sum8;

  logic [1:0] req1w;
  logic [0:0] a0w, b0w, a1w, b1w;
  logic [1:0] gnt1w;
  logic       busy1w, done1w, done_id1w, cout1w;
  logic [0:0] sum1w;

  int checks = 0;
  int errors = 0;

  serial_add_arb #(.WIDTH(8)) dut8 (
    .CLK(CLK), .Reset_L(Reset_L), .req(req8),
    .a0(a0_8), .b0(b0_8), .a1(a1_8), .b1(b1_8),
    .gnt(gnt8), .busy(busy8), .done(done8), .done_id(done_id8),
    .sum(sum8), .cout(cout8)
  );

  serial_add_arb #(.WIDTH(1)) dut1 (
    .CLK(CLK), .Reset_L(Reset_L), .req(req1w),
    .a0(a0w), .b0(b0w), .a1(a1w), .b1(b1w),
    .gnt(gnt1w), .busy(busy1w), .done(done1w), .done_id(done_id1w),
    .sum(sum1w), .cout(cout1w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for a grant, then for the matching done on the WIDTH=8 instance.
  task automatic txn8(input string tag, input logic exp_id, input logic [7:0] es,
                      input logic ec, input bit drop, input bit clear_at_done,
                      input bit scramble, output int gwait);
    int n = 0;
    int k = 0;
    int busy_cnt = 0;
    logic held = 1'b1;
    logic [7:0] prev;
    do begin
      @(negedge CLK);
      n++;
    end while (gnt8 == 2'b00 && n < 30);
    gwait = n;
    chk({tag, " gnt"}, gnt8, exp_id ? 2'b10 : 2'b01);
    prev = sum8;
    if (drop) req8[exp_id] = 1'b0;
    if (busy8) busy_cnt++;
    while (!done8 && k < 30) begin
      if (scramble) begin
        req8 = ~req8;
        a0_8 = 8'($urandom);
        b0_8 = 8'($urandom);
      end
      @(negedge CLK);
      k++;
      if (busy8) busy_cnt++;
      if (!done8 && sum8 !== prev) held = 1'b0;
    end
    if (clear_at_done || scramble) req8 = 2'b00;
    chk({tag, " latency"}, k, 8);
    chk({tag, " done"}, done8, 1'b1);
    chk({tag, " sum"}, sum8, es);
    chk({tag, " cout"}, cout8, ec);
    chk({tag, " done_id"}, done_id8, exp_id);
    chk({tag, " busy cycles"}, busy_cnt, 9);
    chk({tag, " sum held"}, held, 1'b1);
    @(negedge CLK);
    chk({tag, " done pulse"}, done8, 1'b0);
    chk({tag, " busy idle"}, busy8, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gw;
    int dn;
    Reset_L = 1'b0;
    req8 = '0; a0_8 = '0; b0_8 = '0; a1_8 = '0; b1_8 = '0;
    req1w = '0; a0w = '0; b0w = '0; a1w = '0; b1w = '0;

    @(negedge CLK);
    chk("rst gnt", gnt8, 2'b00);
    chk("rst busy", busy8, 1'b0);
    chk("rst done", done8, 1'b0);
    chk("rst done_id", done_id8, 1'b0);
    chk("rst sum", sum8, 8'h00);
    chk("rst cout", cout8, 1'b0);
    Reset_L = 1'b1;

    // Single requester 0: request presented, captured on the next edge.
    req8 = 2'b01; a0_8 = 8'h5A; b0_8 = 8'h3C;
    txn8("t1", 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b0, gw);
    chk("t1 grant wait", gw, 1);

    req8 = 2'b10; a1_8 = 8'hFF; b1_8 = 8'h01;
    txn8("t2", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, gw);
    req8 = 2'b10; a1_8 = 8'h80; b1_8 = 8'h80;
    txn8("t3", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, gw);

    // Inputs disturbed throughout RUN must not reach the result.
    req8 = 2'b01; a0_8 = 8'h77; b0_8 = 8'h11;
    txn8("scr", 1'b0, 8'h88, 1'b0, 1'b1, 1'b0, 1'b1, gw);

    // Both requesting from reset: strict alternation starting at 0.
    Reset_L = 1'b0;
    req8 = 2'b11;
    a0_8 = 8'h12; b0_8 = 8'h34; a1_8 = 8'hF0; b1_8 = 8'h20;
    @(negedge CLK);
    Reset_L = 1'b1;
    txn8("alt0", 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, gw);
    chk("alt0 grant wait", gw, 1);
    txn8("alt1", 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, gw);
    chk("alt1 grant wait", gw, 1);
    txn8("alt2", 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, gw);
    txn8("alt3", 1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, gw);

    // Asynchronous reset in the middle of RUN.
    req8 = 2'b01; a0_8 = 8'h0F; b0_8 = 8'h01;
    @(negedge CLK);
    chk("abort gnt", gnt8, 2'b01);
    req8 = 2'b00;
    repeat (4) @(negedge CLK);
    chk("abort busy before", busy8, 1'b1);
    #2 Reset_L = 1'b0;
    #1;
    chk("abort gnt0", gnt8, 2'b00);
    chk("abort busy0", busy8, 1'b0);
    chk("abort done0", done8, 1'b0);
    chk("abort done_id0", done_id8, 1'b0);
    chk("abort sum0", sum8, 8'h00);
    chk("abort cout0", cout8, 1'b0);
    @(negedge CLK);
    Reset_L = 1'b1;
    dn = 0;
    repeat (15) begin
      @(negedge CLK);
      if (done8) dn++;
    end
    chk("abort no done", dn, 0);
    req8 = 2'b10; a1_8 = 8'h03; b1_8 = 8'h04;
    txn8("after", 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, gw);

    // WIDTH=1 instance.
    req1w = 2'b01; a0w = 1'b1; b0w = 1'b1;
    @(negedge CLK);
    chk("w1 gnt0", gnt1w, 2'b01);
    req1w = 2'b00;
    @(negedge CLK);
    chk("w1 done a", done1w, 1'b1);
    chk("w1 sum a", sum1w, 1'b0);
    chk("w1 cout a", cout1w, 1'b1);
    chk("w1 id a", done_id1w, 1'b0);
    @(negedge CLK);
    chk("w1 done pulse", done1w, 1'b0);
    chk("w1 busy idle", busy1w, 1'b0);
    req1w = 2'b10; a1w = 1'b0; b1w = 1'b1;
    @(negedge CLK);
    chk("w1 gnt1", gnt1w, 2'b10);
    req1w = 2'b00;
    @(negedge CLK);
    chk("w1 done b", done1w, 1'b1);
    chk("w1 sum b", sum1w, 1'b1);
    chk("w1 cout b", cout1w, 1'b0);
    chk("w1 id b", done_id1w, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
